serial_capture_ctrl: RTL and testbench

- Framed serial-to-parallel capture controller that sequences a WIDTH-bit shift datapath from the single-bit serial line D.
- Detects a start bit, then samples D at mid-bit on a fixed cycle grid and shifts the data bits in MSB first.
- Checks the stop bit, then presents the word on Q with a one-cycle Valid strobe.
- ShiftEn is exported so an external shift register on the same line can be stepped in lockstep.

---
 rtl/serial_capture_ctrl_if.sv | 33 +++
 rtl/serial_capture_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_serial_capture_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_capture_ctrl_if.sv
// Signal bundle between a framed serial line source and serial_capture_ctrl.
// The source drives D/Enable; the controller returns the captured word and status strobes.
interface serial_capture_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             D;
    logic             Enable;
    logic             ShiftEn;
    logic [WIDTH-1:0] Q;
    logic             Valid;
    logic             Err;
    logic             Busy;

    modport master (
        output D,
        output Enable,
        input  ShiftEn,
        input  Q,
        input  Valid,
        input  Err,
        input  Busy
    );

    modport slave (
        input  D,
        input  Enable,
        output ShiftEn,
        output Q,
        output Valid,
        output Err,
        output Busy
    );
endinterface

// File: rtl/serial_capture_ctrl.sv
// Framed serial-to-parallel capture controller: start bit, WIDTH data bits MSB first, stop bit.
// Optional even-parity bit before the stop bit when SERIAL_CAPTURE_PARITY_EN is defined.
module serial_capture_ctrl #(
    parameter int WIDTH      = 4,
    parameter int BIT_CYCLES = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    serial_capture_ctrl_if.slave bus
);

    localparam int HALF = BIT_CYCLES / 2;
    localparam int CW   = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam int BW   = $clog2(WIDTH);

    localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_HALF_LAST = CW'(HALF - 1);
    localparam logic [BW-1:0] BIDX_LAST     = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SERIAL_CAPTURE_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_RECOVER
    } state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [BW-1:0]    bidx, bidx_next;
    logic [WIDTH-1:0] shift, shift_next;
    logic [WIDTH-1:0] q, q_next;
    logic             valid, valid_next;
    logic             err, err_next;
    logic             shift_en, shift_en_next;
    logic             busy, busy_next;
    logic             stop_ok;
`ifdef SERIAL_CAPTURE_PARITY_EN
    logic             parity_bit, parity_next;
`endif

    // A good stop bit only commits the word when the parity (if present) also checks out.
`ifdef SERIAL_CAPTURE_PARITY_EN
    assign stop_ok = ((^shift) ^ parity_bit) == 1'b0;
`else
    assign stop_ok = 1'b1;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bidx     <= '0;
            shift    <= '0;
            q        <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
            shift_en <= 1'b0;
            busy     <= 1'b0;
`ifdef SERIAL_CAPTURE_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            bidx     <= bidx_next;
            shift    <= shift_next;
            q        <= q_next;
            valid    <= valid_next;
            err      <= err_next;
            shift_en <= shift_en_next;
            busy     <= busy_next;
`ifdef SERIAL_CAPTURE_PARITY_EN
            parity_bit <= parity_next;
`endif
        end
    end

    // cnt counts cycles since the last sample point; every sample lands on cnt == last.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt + CW'(1);
        bidx_next     = bidx;
        shift_next    = shift;
        q_next        = q;
        valid_next    = 1'b0;
        err_next      = 1'b0;
        shift_en_next = 1'b0;
`ifdef SERIAL_CAPTURE_PARITY_EN
        parity_next   = parity_bit;
`endif

        case (state)
            S_IDLE: begin
                cnt_next = '0;
                if (bus.Enable && bus.D) begin
                    state_next = S_START;
                end
            end

            S_START: begin
                if (cnt == CNT_HALF_LAST) begin
                    cnt_next = '0;
                    if (bus.D) begin
                        state_next = S_DATA;
                        bidx_next  = '0;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end

            S_DATA: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_next      = '0;
                    shift_next    = {shift[WIDTH-2:0], bus.D};
                    shift_en_next = 1'b1;
                    if (bidx == BIDX_LAST) begin
`ifdef SERIAL_CAPTURE_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end else begin
                        bidx_next = bidx + BW'(1);
                    end
                end
            end

`ifdef SERIAL_CAPTURE_PARITY_EN
            S_PARITY: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_next    = '0;
                    parity_next = bus.D;
                    state_next  = S_STOP;
                end
            end
`endif

            S_STOP: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_next = '0;
                    if (!bus.D) begin
                        state_next = S_IDLE;
                        if (stop_ok) begin
                            q_next     = shift;
                            valid_next = 1'b1;
                        end else begin
                            err_next = 1'b1;
                        end
                    end else begin
                        err_next   = 1'b1;
                        state_next = S_RECOVER;
                    end
                end
            end

            // Wait out a stuck-high line so it cannot be mistaken for a new start bit.
            S_RECOVER: begin
                cnt_next = '0;
                if (!bus.D) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                cnt_next   = '0;
                state_next = S_IDLE;
            end
        endcase

        busy_next = (state_next != S_IDLE);
    end

    assign bus.Q       = q;
    assign bus.Valid   = valid;
    assign bus.Err     = err;
    assign bus.ShiftEn = shift_en;
    assign bus.Busy    = busy;

endmodule

// File: tb/tb_serial_capture_ctrl.sv
// Directed testbench for serial_capture_ctrl (WIDTH=4, BIT_CYCLES=4).
// Define SERIAL_CAPTURE_PARITY_EN to exercise the parity frame format.
module tb_serial_capture_ctrl;

    localparam int WIDTH      = 4;
    localparam int BIT_CYCLES = 4;
    localparam int HALF       = BIT_CYCLES / 2;
`ifdef SERIAL_CAPTURE_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    // Observation index k holds outputs after edge E0+k-1, so the stop sample at E0+22 shows at 23.
    localparam int VALID_IDX = 1 + HALF + (WIDTH + 1 + PAR) * BIT_CYCLES;
    localparam int MAXREC    = 256;

    logic Clk = 1'b0;
    logic Rst;
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    serial_capture_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_capture_ctrl #(
        .WIDTH      (WIDTH),
        .BIT_CYCLES (BIT_CYCLES)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    logic             line_q[$];
    int               rst_at = -1;
    int               nrec   = 0;
    logic             rec_valid [MAXREC];
    logic             rec_err   [MAXREC];
    logic             rec_sen   [MAXREC];
    logic             rec_busy  [MAXREC];
    logic [WIDTH-1:0] rec_q     [MAXREC];

    task automatic add_bits(input logic v, input int n);
        for (int i = 0; i < n; i++) line_q.push_back(v);
    endtask

    // Start bit, data MSB first, optional parity, then stop_len cycles of stop_v.
    task automatic add_frame(input logic [WIDTH-1:0] data, input logic stop_v,
                             input int stop_len, input logic par_v);
        add_bits(1'b1, BIT_CYCLES);
        for (int i = WIDTH - 1; i >= 0; i--) add_bits(data[i], BIT_CYCLES);
        if (PAR == 1) add_bits(par_v, BIT_CYCLES);
        add_bits(stop_v, stop_len);
    endtask

    task automatic play();
        int n;
        n = line_q.size();
        for (int k = 0; k <= n && k < MAXREC; k++) begin
            @(negedge Clk);
            rec_valid[k] = bus.Valid;
            rec_err[k]   = bus.Err;
            rec_sen[k]   = bus.ShiftEn;
            rec_busy[k]  = bus.Busy;
            rec_q[k]     = bus.Q;
            bus.D = (k < n) ? line_q[k] : 1'b0;
            Rst   = (k == rst_at);
        end
        nrec = n + 1;
        line_q.delete();
        rst_at = -1;
    endtask

    function automatic int count_pulses(input int sel);
        int c;
        c = 0;
        for (int k = 1; k < nrec; k++) begin
            case (sel)
                0: c += int'(rec_valid[k]);
                1: c += int'(rec_err[k]);
                2: c += int'(rec_sen[k]);
                default: c += int'(rec_busy[k]);
            endcase
        end
        return c;
    endfunction

    task automatic test_reset();
        Rst = 1'b1;
        bus.D = 1'b0;
        bus.Enable = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checks++; if (bus.Q !== 4'h0) begin errors++; $display("[TB] FAIL reset_q: got %0h expected 0", bus.Q); end
        checks++; if (bus.Valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.Valid); end
        checks++; if (bus.Err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.Err); end
        checks++; if (bus.ShiftEn !== 1'b0) begin errors++; $display("[TB] FAIL reset_shiften: got %b expected 0", bus.ShiftEn); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.Busy); end
        Rst = 1'b0;
        bus.Enable = 1'b1;
    endtask

    task automatic test_good_frame();
        add_frame(4'hA, 1'b0, BIT_CYCLES, 1'b0);
        add_bits(1'b0, 4);
        play();
        checks++; if (count_pulses(0) !== 1) begin errors++; $display("[TB] FAIL good_valid_count: got %0d expected 1", count_pulses(0)); end
        checks++; if (rec_valid[VALID_IDX] !== 1'b1) begin errors++; $display("[TB] FAIL good_valid_time: got %b expected 1", rec_valid[VALID_IDX]); end
        checks++; if (rec_q[VALID_IDX] !== 4'hA) begin errors++; $display("[TB] FAIL good_q: got %0h expected a", rec_q[VALID_IDX]); end
        checks++; if (count_pulses(2) !== 4) begin errors++; $display("[TB] FAIL good_shiften_count: got %0d expected 4", count_pulses(2)); end
        checks++; if (rec_sen[7] !== 1'b1 || rec_sen[19] !== 1'b1) begin errors++; $display("[TB] FAIL good_shiften_time: got %b%b expected 11", rec_sen[7], rec_sen[19]); end
        checks++; if (count_pulses(1) !== 0) begin errors++; $display("[TB] FAIL good_err: got %0d expected 0", count_pulses(1)); end
        checks++; if (rec_busy[VALID_IDX-1] !== 1'b1 || rec_busy[VALID_IDX] !== 1'b0) begin errors++; $display("[TB] FAIL good_busy_end: got %b%b expected 10", rec_busy[VALID_IDX-1], rec_busy[VALID_IDX]); end
    endtask

    task automatic test_glitch();
        add_bits(1'b1, 1);
        add_bits(1'b0, 8);
        play();
        checks++; if (count_pulses(3) !== 2) begin errors++; $display("[TB] FAIL glitch_busy_cycles: got %0d expected 2", count_pulses(3)); end
        checks++; if (rec_busy[1] !== 1'b1 || rec_busy[3] !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy_shape: got %b%b expected 10", rec_busy[1], rec_busy[3]); end
        checks++; if (count_pulses(0) + count_pulses(1) !== 0) begin errors++; $display("[TB] FAIL glitch_strobes: got %0d expected 0", count_pulses(0) + count_pulses(1)); end
        checks++; if (rec_q[nrec-1] !== 4'hA) begin errors++; $display("[TB] FAIL glitch_q: got %0h expected a", rec_q[nrec-1]); end
    endtask

    task automatic test_framing_error();
        int low_idx;
        low_idx = VALID_IDX + 11;
        add_frame(4'h5, 1'b1, BIT_CYCLES + 10, 1'b0);
        add_bits(1'b0, 6);
        play();
        checks++; if (count_pulses(1) !== 1 || rec_err[VALID_IDX] !== 1'b1) begin errors++; $display("[TB] FAIL ferr_err: got %0d pulses expected 1 at %0d", count_pulses(1), VALID_IDX); end
        checks++; if (count_pulses(0) !== 0) begin errors++; $display("[TB] FAIL ferr_valid: got %0d expected 0", count_pulses(0)); end
        checks++; if (rec_q[nrec-1] !== 4'hA) begin errors++; $display("[TB] FAIL ferr_q: got %0h expected a", rec_q[nrec-1]); end
        checks++; if (rec_busy[low_idx] !== 1'b1 || rec_busy[low_idx+1] !== 1'b0) begin errors++; $display("[TB] FAIL ferr_recover: got %b%b expected 10", rec_busy[low_idx], rec_busy[low_idx+1]); end
        checks++; if (rec_busy[nrec-1] !== 1'b0) begin errors++; $display("[TB] FAIL ferr_no_restart: got %b expected 0", rec_busy[nrec-1]); end
    endtask

    task automatic test_reset_mid_data();
        add_bits(1'b1, BIT_CYCLES);
        add_bits(1'b1, 2 * BIT_CYCLES);
        add_bits(1'b0, 8);
        rst_at = 11;
        play();
        checks++; if (rec_q[12] !== 4'h0 || rec_busy[12] !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_q_busy: got q=%0h busy=%b expected q=0 busy=0", rec_q[12], rec_busy[12]); end
        checks++; if (rec_valid[12] !== 1'b0 || rec_err[12] !== 1'b0 || rec_sen[12] !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_strobes: got %b%b%b expected 000", rec_valid[12], rec_err[12], rec_sen[12]); end
        checks++; if (rec_busy[nrec-1] !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_idle: got %b expected 0", rec_busy[nrec-1]); end
        add_frame(4'h3, 1'b0, BIT_CYCLES, 1'b0);
        add_bits(1'b0, 4);
        play();
        checks++; if (rec_valid[VALID_IDX] !== 1'b1 || rec_q[VALID_IDX] !== 4'h3) begin errors++; $display("[TB] FAIL rst_mid_next_frame: got valid=%b q=%0h expected valid=1 q=3", rec_valid[VALID_IDX], rec_q[VALID_IDX]); end
    endtask

    task automatic test_back_to_back();
        int second;
        bus.Enable = 1'b0;
        add_frame(4'hC, 1'b0, BIT_CYCLES, 1'b0);
        add_bits(1'b0, 4);
        play();
        checks++; if (count_pulses(3) !== 0 || count_pulses(0) !== 0) begin errors++; $display("[TB] FAIL enable_gate: got busy=%0d valid=%0d expected 0 0", count_pulses(3), count_pulses(0)); end
        checks++; if (rec_q[nrec-1] !== 4'h3) begin errors++; $display("[TB] FAIL enable_gate_q: got %0h expected 3", rec_q[nrec-1]); end
        bus.Enable = 1'b1;
        add_frame(4'h9, 1'b0, BIT_CYCLES, 1'b0);
        second = line_q.size();
        add_frame(4'h6, 1'b0, BIT_CYCLES, 1'b0);
        add_bits(1'b0, 4);
        play();
        checks++; if (count_pulses(0) !== 2) begin errors++; $display("[TB] FAIL b2b_valid_count: got %0d expected 2", count_pulses(0)); end
        checks++; if (rec_valid[VALID_IDX] !== 1'b1 || rec_q[VALID_IDX] !== 4'h9) begin errors++; $display("[TB] FAIL b2b_first: got valid=%b q=%0h expected valid=1 q=9", rec_valid[VALID_IDX], rec_q[VALID_IDX]); end
        checks++; if (rec_valid[second+VALID_IDX] !== 1'b1 || rec_q[second+VALID_IDX] !== 4'h6) begin errors++; $display("[TB] FAIL b2b_second: got valid=%b q=%0h expected valid=1 q=6", rec_valid[second+VALID_IDX], rec_q[second+VALID_IDX]); end
        checks++; if (count_pulses(1) !== 0) begin errors++; $display("[TB] FAIL b2b_err: got %0d expected 0", count_pulses(1)); end
    endtask

`ifdef SERIAL_CAPTURE_PARITY_EN
    task automatic test_parity();
        add_frame(4'hB, 1'b0, BIT_CYCLES, 1'b1);
        add_bits(1'b0, 4);
        play();
        checks++; if (rec_valid[VALID_IDX] !== 1'b1 || rec_q[VALID_IDX] !== 4'hB) begin errors++; $display("[TB] FAIL parity_good: got valid=%b q=%0h expected valid=1 q=b", rec_valid[VALID_IDX], rec_q[VALID_IDX]); end
        checks++; if (count_pulses(2) !== 4) begin errors++; $display("[TB] FAIL parity_shiften: got %0d expected 4", count_pulses(2)); end
        add_frame(4'hB, 1'b0, BIT_CYCLES, 1'b0);
        add_bits(1'b0, 4);
        play();
        checks++; if (rec_err[VALID_IDX] !== 1'b1 || count_pulses(0) !== 0) begin errors++; $display("[TB] FAIL parity_bad_err: got err=%b valid=%0d expected err=1 valid=0", rec_err[VALID_IDX], count_pulses(0)); end
        checks++; if (rec_q[nrec-1] !== 4'hB || rec_busy[nrec-1] !== 1'b0) begin errors++; $display("[TB] FAIL parity_bad_hold: got q=%0h busy=%b expected q=b busy=0", rec_q[nrec-1], rec_busy[nrec-1]); end
    endtask
`endif

    initial begin
        bus.D      = 1'b0;
        bus.Enable = 1'b0;
        Rst        = 1'b1;
        test_reset();
        test_good_frame();
        test_glitch();
        test_framing_error();
        test_reset_mid_data();
        test_back_to_back();
`ifdef SERIAL_CAPTURE_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
